// File: rtl/mem_access_unit_if.sv
// Data-memory request bus: req/gnt handshake with a separate rvalid read return.
// The access unit drives the request side as master; the memory is the slave.
interface mem_access_unit_if;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          DmReq;
  logic [AW-1:0] DmAddr;
  logic [BW-1:0] DmWe;
  logic [DW-1:0] DmWdata;
  logic          DmGnt;
  logic          DmRvalid;
  logic [DW-1:0] DmRdata;

  modport master (
    output DmReq, DmAddr, DmWe, DmWdata,
    input  DmGnt, DmRvalid, DmRdata
  );

  modport slave (
    input  DmReq, DmAddr, DmWe, DmWdata,
    output DmGnt, DmRvalid, DmRdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one word access per memory
// instruction, lane-aligns stores, stalls the pipe while busy and owns MEM/WB load fields.
module mem_access_unit (
  input  logic                CPU_CLK,
  input  logic                CPU_RST_N,
  input  logic [31:0]         AluOutM,
  input  logic [31:0]         StoreDataM,
  input  logic [2:0]          RegWriteM,
  input  logic [1:0]          StoreTypeM,
  output logic                StallM,
  mem_access_unit_if.master   dm,
  output logic [31:0]         LoadWordW,
  output logic [1:0]          LoadedBytesSelectW,
  output logic [2:0]          RegWriteW,
  output logic                MisalignErrW
);

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  localparam logic [2:0] RW_NONE  = 3'd0;
  localparam logic [2:0] RW_LB    = 3'd1;
  localparam logic [2:0] RW_LH    = 3'd2;
  localparam logic [2:0] RW_LW    = 3'd3;
  localparam logic [2:0] RW_LBU   = 3'd5;
  localparam logic [2:0] RW_LHU   = 3'd6;

  localparam logic [1:0] ST_NONE  = 2'd0;
  localparam logic [1:0] ST_SB    = 2'd1;
  localparam logic [1:0] ST_SH    = 2'd2;
  localparam logic [1:0] ST_SW    = 2'd3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ld_q, ld_d;
  logic [DW-1:0] word_q, word_d;

  logic          is_load;
  logic          is_store;
  logic          misaligned;
  logic          access_ok;
  logic [BW-1:0] lane_we;
  logic [DW-1:0] lane_wdata;

  // Instruction classification from the MEM-stage controls.
  assign is_load  = RegWriteM inside {RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU};
  assign is_store = (StoreTypeM != ST_NONE);

  always_comb begin
    misaligned = 1'b0;
    case (RegWriteM)
      RW_LH, RW_LHU: misaligned = AluOutM[0];
      RW_LW:         misaligned = |AluOutM[1:0];
      default:       ;
    endcase
    case (StoreTypeM)
      ST_SH:   misaligned = misaligned | AluOutM[0];
      ST_SW:   misaligned = misaligned | (|AluOutM[1:0]);
      default: ;
    endcase
  end

  assign access_ok = (is_load | is_store) & ~misaligned;

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    lane_we    = '0;
    lane_wdata = '0;
    case (StoreTypeM)
      ST_SB: begin
        lane_we    = BW'(4'b0001 << AluOutM[1:0]);
        lane_wdata = {4{StoreDataM[7:0]}};
      end
      ST_SH: begin
        lane_we    = AluOutM[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{StoreDataM[15:0]}};
      end
      ST_SW: begin
        lane_we    = 4'b1111;
        lane_wdata = StoreDataM;
      end
      default: ;
    endcase
  end

  // Stall covers the issuing IDLE cycle and every cycle until the access completes.
  assign StallM = ((state_q == S_IDLE) & access_ok) |
                  (state_q == S_REQ) |
                  (state_q == S_WAIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (access_ok) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = AluOutM[31:2];
          we_d    = lane_we;
          wdata_d = lane_wdata;
          ld_d    = is_load;
        end
      end
      S_REQ: begin
        if (dm.DmGnt) begin
          req_d = 1'b0;
          if (!ld_q) begin
            state_d = S_DONE;
          end else if (dm.DmRvalid) begin
            word_d  = dm.DmRdata;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dm.DmRvalid) begin
          word_d  = dm.DmRdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      ld_q    <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      word_q  <= word_d;
    end
  end

  assign dm.DmReq   = req_q;
  assign dm.DmAddr  = addr_q;
  assign dm.DmWe    = we_q;
  assign dm.DmWdata = wdata_q;

  // MEM/WB fields advance with the pipe; the load word only changes on a completed load.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      LoadWordW          <= '0;
      LoadedBytesSelectW <= '0;
      RegWriteW          <= RW_NONE;
      MisalignErrW       <= 1'b0;
    end else if (!StallM) begin
      RegWriteW          <= misaligned ? RW_NONE : RegWriteM;
      LoadedBytesSelectW <= AluOutM[1:0];
      MisalignErrW       <= misaligned;
      if ((state_q == S_DONE) && ld_q) begin
        LoadWordW <= word_q;
      end
    end
  end

endmodule
